// File: rtl/rst_button_conditioner.sv
// Reset conditioner: synchronises and debounces two reset buttons, gates release on clock lock,
// stretches the core reset and lags the peripheral release. Cause capture enabled by RST_COND_CAUSE_EN.
module rst_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int STRETCH_CYCLES  = 256,
    parameter int PERIPH_LAG      = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fpga_rst_btn,
    input  logic       mcu_rst_btn_n,
    input  logic       mmcm_locked,
    output logic       sys_rst_n,
    output logic       periph_rst,
    output logic [1:0] rst_cause
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAG_LAST = CNT_W'(PERIPH_LAG - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STRETCH,
        S_LAG,
        S_RUN
    } state_t;

    // Bit 0: FPGA button, bit 1: MCU button (active low), bit 2: clock lock.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [1:0]       w_btn_s;
    logic [1:0]       w_btn_db;
    logic             w_locked_s;
    logic             w_press;
    logic             w_abort;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sys_rst_n;
    logic             r_periph_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {mmcm_locked, mcu_rst_btn_n, fpga_rst_btn};
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s    = {~r_sync2[1], r_sync2[0]};
    assign w_locked_s = r_sync2[2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic [CNT_W-1:0] r_db_cnt;
            logic             r_db;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_db_cnt <= '0;
                    r_db     <= 1'b0;
                end else if (w_btn_s[gi] != r_db) begin
                    if (r_db_cnt == DB_LAST) begin
                        r_db     <= w_btn_s[gi];
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_W'(1);
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end

            assign w_btn_db[gi] = r_db;
        end
    endgenerate

    assign w_press = |w_btn_db;
    assign w_abort = w_press | ~w_locked_s;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_HOLD: begin
                w_state_next = S_WAIT_LOCK;
                w_cnt_next   = '0;
            end
            S_WAIT_LOCK: begin
                w_cnt_next = '0;
                if (!w_abort) w_state_next = S_STRETCH;
            end
            S_STRETCH: begin
                if (w_abort) begin
                    w_state_next = S_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == ST_LAST) begin
                    w_state_next = S_LAG;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_LAG: begin
                if (w_abort) begin
                    w_state_next = S_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == LAG_LAST) begin
                    w_state_next = S_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (w_abort) w_state_next = S_WAIT_LOCK;
            end
            default: begin
                w_state_next = S_HOLD;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs follow the next state so assertion of both resets lands on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_sys_rst_n  <= 1'b0;
            r_periph_rst <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_sys_rst_n  <= (w_state_next == S_LAG) || (w_state_next == S_RUN);
            r_periph_rst <= (w_state_next != S_RUN);
        end
    end

    assign sys_rst_n  = r_sys_rst_n;
    assign periph_rst = r_periph_rst;

`ifdef RST_COND_CAUSE_EN
    // Survives rst_n on purpose; starts at 00 from the power-on register value.
    logic [1:0] r_cause = 2'b00;
    logic       w_leaving;

    assign w_leaving = w_abort &&
        ((r_state == S_STRETCH) || (r_state == S_LAG) || (r_state == S_RUN));

    always_ff @(posedge clk) begin
        if (w_leaving) begin
            if (!w_locked_s)     r_cause <= 2'b01;
            else if (w_btn_db[0]) r_cause <= 2'b10;
            else                 r_cause <= 2'b11;
        end
    end

    assign rst_cause = r_cause;
`else
    assign rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_rst_button_conditioner.sv
// Bench for rst_button_conditioner: directed scenarios plus random stimulus against a
// run-length model (core reset releases after an unbroken run of good cycles).
module tb_rst_button_conditioner;
    localparam int DEB = 8;
    localparam int ST  = 16;
    localparam int LAG = 4;
`ifdef RST_COND_CAUSE_EN
    localparam logic [1:0] CAUSE_EXP = 2'b01;
`else
    localparam logic [1:0] CAUSE_EXP = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fpga_rst_btn = 1'b0;
    logic       mcu_rst_btn_n = 1'b1;
    logic       mmcm_locked = 1'b1;
    logic       sys_rst_n;
    logic       periph_rst;
    logic [1:0] rst_cause;

    int errors = 0;
    int checks = 0;

    rst_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (ST),
        .PERIPH_LAG     (LAG),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fpga_rst_btn (fpga_rst_btn),
        .mcu_rst_btn_n(mcu_rst_btn_n),
        .mmcm_locked  (mmcm_locked),
        .sys_rst_n    (sys_rst_n),
        .periph_rst   (periph_rst),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    // Reference model: 2-cycle input delay, windowed debounce, run length of good cycles.
    bit [2:0]   m_s1, m_s2;
    bit         m_deb [2];
    bit         m_hist [2][$];
    int         m_run;
    bit         m_first;
    logic [1:0] m_cause = 2'b00;
    logic       e_sys, e_per;
    logic [1:0] e_cause;

    function automatic void model_reset();
        m_s1 = '0;
        m_s2 = '0;
        for (int b = 0; b < 2; b++) begin
            m_deb[b] = 1'b0;
            m_hist[b].delete();
        end
        m_run   = 0;
        m_first = 1'b1;
        e_sys   = 1'b0;
        e_per   = 1'b1;
        e_cause = m_cause;
    endfunction

    task automatic tick();
        bit       g;
        bit [1:0] v;
        bit       all_diff;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            g = m_s2[2] && !(m_deb[0] || m_deb[1]);
            v = {!m_s2[1], m_s2[0]};
            if (m_first) begin
                m_first = 1'b0;
                m_run   = 0;
            end else begin
`ifdef RST_COND_CAUSE_EN
                if (m_run >= 1 && !g)
                    m_cause = !m_s2[2] ? 2'b01 : (m_deb[0] ? 2'b10 : 2'b11);
`endif
                m_run = g ? m_run + 1 : 0;
            end
            for (int b = 0; b < 2; b++) begin
                m_hist[b].push_back(v[b]);
                if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
                if (m_hist[b].size() == DEB) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (m_hist[b][k] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) m_deb[b] = v[b];
                end
            end
            m_s2 = m_s1;
            m_s1 = {mmcm_locked, mcu_rst_btn_n, fpga_rst_btn};
            e_sys   = (m_run >= ST + 1);
            e_per   = !(m_run >= ST + 1 + LAG);
            e_cause = m_cause;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== 4'b0100) begin
                errors++;
                $display("FAIL reset_state cyc %0d: got sys=%b per=%b cause=%b want sys=0 per=1 cause=00",
                         i, sys_rst_n, periph_rst, rst_cause);
            end
        end
    endtask

    task automatic test_power_on();
        int rise = 0, fall = 0;
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL power_on cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
            if (sys_rst_n === 1'b1 && rise == 0) rise = i;
            if (periph_rst === 1'b0 && fall == 0) fall = i;
        end
        checks++;
        if (rise < ST + 3 || rise > ST + 5) begin
            errors++;
            $display("FAIL power_on_rise: got edge %0d want %0d..%0d", rise, ST + 3, ST + 5);
        end
        checks++;
        if (fall - rise != LAG) begin
            errors++;
            $display("FAIL power_on_lag: got %0d want %0d", fall - rise, LAG);
        end
    endtask

    task automatic test_debounce();
        int fall = 0, rise = 0;
        bit saw_low = 1'b0;
        fpga_rst_btn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            if (i == 6) fpga_rst_btn = 1'b0;
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL glitch cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
            if (sys_rst_n !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low) begin
            errors++;
            $display("FAIL glitch_ignored: got sys_rst_n low want held high");
        end
        fpga_rst_btn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 21) fpga_rst_btn = 1'b0;
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL press20 cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
            if (sys_rst_n === 1'b0 && fall == 0) fall = i;
            if (sys_rst_n === 1'b1 && fall != 0 && rise == 0) rise = i;
        end
        checks++;
        if (fall != 2 + DEB + 1) begin
            errors++;
            $display("FAIL press_latency: got edge %0d want %0d", fall, 2 + DEB + 1);
        end
        checks++;
        if (rise != 20 + 2 + DEB + ST + 1) begin
            errors++;
            $display("FAIL press_rerelease: got edge %0d want %0d", rise, 20 + 2 + DEB + ST + 1);
        end
    endtask

    task automatic test_lock_loss();
        int fall = 0, rise = 0, pfall = 0;
        mmcm_locked = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 2) mmcm_locked = 1'b1;
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL lock_loss cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
            if (sys_rst_n === 1'b0 && fall == 0) fall = i;
            if (sys_rst_n === 1'b1 && fall != 0 && rise == 0) rise = i;
            if (periph_rst === 1'b0 && rise != 0 && pfall == 0) pfall = i;
        end
        checks++;
        if (fall != 3) begin
            errors++;
            $display("FAIL lock_latency: got edge %0d want 3", fall);
        end
        checks++;
        if (rise != 3 + ST + 1 || pfall != 3 + ST + 1 + LAG) begin
            errors++;
            $display("FAIL lock_rerelease: got rise %0d pfall %0d want %0d %0d",
                     rise, pfall, 3 + ST + 1, 3 + ST + 1 + LAG);
        end
    endtask

    task automatic test_mcu_hold();
        int rise = 0;
        bit high_during = 1'b0;
        mcu_rst_btn_n = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            if (i == 101) mcu_rst_btn_n = 1'b1;
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL mcu_hold cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
            if (i >= 2 + DEB + 1 && sys_rst_n !== 1'b0 && rise == 0) begin
                if (i < 100 + 2 + DEB + ST + 1) high_during = 1'b1;
                else rise = i;
            end
        end
        checks++;
        if (high_during || rise != 100 + 2 + DEB + ST + 1) begin
            errors++;
            $display("FAIL mcu_hold_release: got early=%0b rise %0d want early=0 rise %0d",
                     high_during, rise, 100 + 2 + DEB + ST + 1);
        end
    endtask

    task automatic test_reset_mid_sequence();
        int rise = 0;
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({sys_rst_n, periph_rst} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_stretch: got sys=%b per=%b want sys=0 per=1", sys_rst_n, periph_rst);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= ST + 4; i++) begin
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL restart cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
            if (sys_rst_n === 1'b1 && rise == 0) rise = i;
        end
        checks++;
        if (rise < ST + 3 || rise > ST + 5) begin
            errors++;
            $display("FAIL restart_rise: got edge %0d want %0d..%0d", rise, ST + 3, ST + 5);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({sys_rst_n, periph_rst} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_lag: got sys=%b per=%b want sys=0 per=1", sys_rst_n, periph_rst);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
    endtask

    task automatic test_cause_priority();
        mcu_rst_btn_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 9) mmcm_locked = 1'b0;
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL cause_seq cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
        end
        checks++;
        if (rst_cause !== CAUSE_EXP) begin
            errors++;
            $display("FAIL cause_priority: got %b want %b", rst_cause, CAUSE_EXP);
        end
        mcu_rst_btn_n = 1'b1;
        mmcm_locked   = 1'b1;
        for (int i = 0; i < 40; i++) tick();
    endtask

    task automatic test_random();
        int hold [3] = '{0, 0, 0};
        for (int i = 0; i < 4000; i++) begin
            if (hold[0] == 0) begin
                fpga_rst_btn = ($urandom_range(0, 99) < 20);
                hold[0] = fpga_rst_btn ? $urandom_range(1, 25) : $urandom_range(20, 150);
            end
            if (hold[1] == 0) begin
                mcu_rst_btn_n = ($urandom_range(0, 99) >= 20);
                hold[1] = mcu_rst_btn_n ? $urandom_range(20, 150) : $urandom_range(1, 25);
            end
            if (hold[2] == 0) begin
                mmcm_locked = ($urandom_range(0, 99) < 85);
                hold[2] = mmcm_locked ? $urandom_range(20, 150) : $urandom_range(1, 10);
            end
            for (int k = 0; k < 3; k++) hold[k]--;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            tick();
            checks++;
            if ({sys_rst_n, periph_rst, rst_cause} !== {e_sys, e_per, e_cause}) begin
                errors++;
                $display("FAIL random cyc %0d: got %b%b%b want %b%b%b", i,
                         sys_rst_n, periph_rst, rst_cause, e_sys, e_per, e_cause);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_on();
        test_debounce();
        for (int i = 0; i < 10; i++) tick();
        test_lock_loss();
        for (int i = 0; i < 10; i++) tick();
        test_mcu_hold();
        for (int i = 0; i < 10; i++) tick();
        test_cause_priority();
        test_reset_mid_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
